// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the MIPS datapath.
// Executes MULT, MULTU, DIV and DIVU over WIDTH iterations on operand
// magnitudes, applies a sign fixup on the final iteration, and holds the
// result in HI/LO for MFHI/MFLO. Start/Busy/Done let control stall until
// the result is valid.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 res_neg_q, res_neg_d;   // negate product / quotient
  logic                 rem_neg_q, rem_neg_d;   // negate remainder
  logic                 div_zero_q, div_zero_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;           // {upper, lower} working register
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Operand preparation for acceptance.
  logic                 op_signed, op_div, div_by_zero;
  logic [WIDTH-1:0]     a_mag, b_mag;

  // One iteration of each algorithm, and the fixed-up final result.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_shift;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  assign op_signed   = ~Op[0];
  assign op_div      = Op[1];
  assign div_by_zero = op_div && (Operand_B == '0);
  // abs() of the most negative value wraps to itself, which is the correct
  // unsigned magnitude.
  assign a_mag = (op_signed && Operand_A[WIDTH-1]) ? -Operand_A : Operand_A;
  assign b_mag = (op_signed && Operand_B[WIDTH-1]) ? -Operand_B : Operand_B;

  // Single iteration step of shift-add multiply and restoring divide.
  always_comb begin
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole register right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the partial remainder and
    // subtract the divisor when it fits; the remainder then fits in WIDTH.
    rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge    = (rem_shift >= {1'b0, opnd_q});
    rem_new   = rem_ge ? WIDTH'(rem_shift - {1'b0, opnd_q}) : rem_shift[WIDTH-1:0];
    div_next  = {rem_new, acc_q[WIDTH-2:0], rem_ge};

    // Sign fixup applied to the final iteration's result.
    mul_prod = res_neg_q ? -mul_next : mul_next;
    quot_fix = res_neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -rem_new : rem_new;
  end

  // Next-state and datapath control for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path can infer a latch.
    state_d    = state_q;
    is_div_d   = is_div_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          is_div_d   = op_div;
          res_neg_d  = op_signed && (Operand_A[WIDTH-1] ^ Operand_B[WIDTH-1]);
          rem_neg_d  = op_signed && Operand_A[WIDTH-1];
          cnt_d      = '0;
          div_zero_d = 1'b0;
          if (op_div) begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
          end
          if (div_by_zero) begin
            hi_d       = Operand_A;
            lo_d       = '1;
            div_zero_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = mul_prod[2*WIDTH-1:WIDTH];
            lo_d = mul_prod[WIDTH-1:0];
          end
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_DONE);
  assign Div_Zero = div_zero_q;
  assign Hi       = hi_q;
  assign Lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] Operand_A = '0;
  logic [31:0] Operand_B = '0;
  logic        Busy, Done, Div_Zero;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Op        (Op),
    .Operand_A (Operand_A),
    .Operand_B (Operand_B),
    .Busy      (Busy),
    .Done      (Done),
    .Div_Zero  (Div_Zero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the MIPS arithmetic definitions.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      sp, sq, sr;
    logic [63:0] up;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = sp;
        {hi, lo} = up;
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        {hi, lo} = up;
      end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1;
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          lo = sq[31:0];
          hi = sr[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endtask

  // Issue one operation, follow it to Done and check timing and result.
  // pulse_at > 0 raises Start again that many cycles into the run.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int pulse_at);
    logic [31:0] eh, el, hi0, lo0;
    logic        edz;
    int          n, lat_exp, busy_cnt;
    bit          held;
    model(op, a, b, eh, el, edz);
    lat_exp = edz ? 0 : 32;
    @(negedge Clock);
    hi0 = Hi;
    lo0 = Lo;
    Start = 1'b1;
    Op = op;
    Operand_A = a;
    Operand_B = b;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    Op = 2'($urandom);
    Operand_A = $urandom;
    Operand_B = $urandom;
    check({tag, "_dz_accept"}, 32'(Div_Zero), 32'(edz));
    n = 0;
    held = 1'b1;
    busy_cnt = 0;
    while (Done !== 1'b1 && n < 40) begin
      if (Busy === 1'b1) busy_cnt++;
      if (Hi !== hi0 || Lo !== lo0) held = 1'b0;
      Start = (pulse_at > 0 && n == pulse_at);
      if (Start) begin
        Op = 2'($urandom);
        Operand_B = 32'd0;
      end
      @(negedge Clock);
      n++;
    end
    Start = 1'b0;
    if (Busy === 1'b1) busy_cnt++;
    check({tag, "_latency"}, 32'(n), 32'(lat_exp));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat_exp + 1));
    check({tag, "_hilo_held"}, 32'(held), 32'd1);
    check({tag, "_hi"}, Hi, eh);
    check({tag, "_lo"}, Lo, el);
    check({tag, "_dz"}, 32'(Div_Zero), 32'(edz));
    @(negedge Clock);
    check({tag, "_idle_after"}, {30'd0, Busy, Done}, 32'd0);
    check({tag, "_hi_hold"}, Hi, eh);
  endtask

  initial begin
    logic [31:0] hi0, lo0, ra, rb;
    logic [1:0]  rop;
    bit          held, busy_ok;
    int          pulse, sel;

    // Reset state.
    #1;
    check("rst_hi", Hi, 32'd0);
    check("rst_lo", Lo, 32'd0);
    check("rst_flags", {29'd0, Busy, Done, Div_Zero}, 32'd0);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clock);
    check("idle_no_start", {30'd0, Busy, Done}, 32'd0);

    // Test plan cases.
    do_op("mult_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD, 0);
    check("t1_hi", Hi, 32'hFFFF_FFFF);
    check("t1_lo", Lo, 32'hFFFF_FFEB);
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("t2_hi", Hi, 32'hFFFF_FFFE);
    check("t2_lo", Lo, 32'h0000_0001);
    do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    check("t3a_hi", Hi, 32'hFFFF_FFFF);
    check("t3a_lo", Lo, 32'hFFFF_FFFD);
    do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 0);
    check("t3b_hi", Hi, 32'd2);
    check("t3b_lo", Lo, 32'd14);
    do_op("divu_zero", 2'b11, 32'h1234_5678, 32'd0, 0);
    check("t4_hi", Hi, 32'h1234_5678);
    check("t4_lo", Lo, 32'hFFFF_FFFF);
    check("t4_dz_held", 32'(Div_Zero), 32'd1);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("t5_hi", Hi, 32'h0000_0000);
    check("t5_lo", Lo, 32'h8000_0000);
    do_op("div_zero_signed", 2'b10, 32'h8765_4321, 32'd0, 0);
    do_op("mult_pulse", 2'b00, 32'hFFFF_FFF0, 32'd9, 12);

    // Randomized operations with occasional corner operands.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) ra = 32'h8000_0000;
      if (sel == 2) rb = 32'hFFFF_FFFF;
      if (sel == 3) rb = 32'($urandom_range(1, 20));
      pulse = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, pulse);
    end

    // Ignored Start mid-run, then asynchronous reset mid-operation.
    do_op("pre_t6", 2'b01, 32'h0000_1234, 32'h0001_0000, 0);
    @(negedge Clock);
    hi0 = Hi;
    lo0 = Lo;
    Start = 1'b1;
    Op = 2'b00;
    Operand_A = 32'd3;
    Operand_B = 32'd5;
    @(posedge Clock);
    held = 1'b1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge Clock);
      if (Hi !== hi0 || Lo !== lo0) held = 1'b0;
      if (Busy !== 1'b1 || Done !== 1'b0) busy_ok = 1'b0;
      Start = (k == 10);
      Op = 2'b11;
      Operand_A = 32'hDEAD_BEEF;
      Operand_B = 32'd0;
      @(posedge Clock);
    end
    @(negedge Clock);
    Start = 1'b0;
    check("t6_hilo_held", 32'(held), 32'd1);
    check("t6_busy_run", 32'(busy_ok), 32'd1);
    check("t6_no_dz", 32'(Div_Zero), 32'd0);
    @(posedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    check("t6_rst_flags", {29'd0, Busy, Done, Div_Zero}, 32'd0);
    check("t6_rst_hi", Hi, 32'd0);
    check("t6_rst_lo", Lo, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    do_op("t6_after", 2'b00, 32'd3, 32'd5, 0);
    check("t6_lo15", Lo, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative 32-bit multiply/divide unit for the MIPS datapath, fed directly by the register file's Read_Data1/Read_Data2 outputs. It executes MULT, MULTU, DIV and DIVU over 32 iterations and holds the result in internal HI/LO registers. HI/LO are read by MFHI/MFLO through the Hi/Lo ports. A Start/Busy/Done handshake lets the control unit stall until the result is valid.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH

Ports:
Clock  input  1  system clock; all state changes on the rising edge
Reset_n  input  1  asynchronous active-low reset
Start  input  1  request; sampled only when idle (Busy=0)
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
Operand_A  input  WIDTH  rs value (multiplicand / dividend), from Read_Data1
Operand_B  input  WIDTH  rt value (multiplier / divisor), from Read_Data2
Busy  output  1  high while an operation is in progress or completing
Done  output  1  one-cycle pulse; Hi/Lo are valid in this cycle
Div_Zero  output  1  high with Done when a DIV/DIVU had divisor 0; held until the next accepted Start
Hi  output  WIDTH  HI register (product upper half / remainder)
Lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State goes to IDLE.
  - Busy, Done, Div_Zero, Hi, Lo and the iteration counter clear to 0.
  - Reset mid-operation aborts the operation; no partial result is kept.
- State machine IDLE -> RUN -> DONE -> IDLE. Busy = (state != IDLE). Done = (state == DONE).
- IDLE, on an edge with Start=1 (edge E0):
  - Latch Op.
  - For signed ops, latch |A| and |B|, plus the result sign (A[31]^B[31]) and the remainder sign (A[31]).
  - For unsigned ops, latch raw operands.
  - Clear the counter, clear Div_Zero, go to RUN.
  - Start=0 in IDLE: no change.
- Divide by zero (DIV/DIVU with Operand_B==0) at E0:
  - Go directly to DONE.
  - Write Hi=Operand_A, Lo=all ones.
  - Set Div_Zero=1.
  - Done is high in the cycle after E0.
- RUN: one iteration per edge, E1..E32.
  - Multiply: shift-add into a 2*WIDTH accumulator; LSB of the multiplier selects the add.
  - Divide: restoring shift-subtract; the quotient bit is 1 when the partial remainder >= divisor.
  - On E32 (counter == WIDTH-1):
    - Apply sign fixup for signed ops: two's-complement negate the product/quotient if the result sign is 1; negate the remainder if the remainder sign is 1.
    - Write Hi/Lo and go to DONE.
  - Hi/Lo keep their previous values throughout RUN.
- DONE: one cycle, then IDLE on the next edge. Start is ignored in DONE and in RUN; there is no queueing.
- Latency:
  - Normal operation: Done high in the cycle after E32, i.e. 32 edges after acceptance. Busy is high for 33 cycles.
  - Divide by zero: Done high in the cycle after E0 (1 edge after acceptance). Busy is high for 1 cycle.
- Arithmetic: all internal arithmetic is unsigned on magnitudes. abs(0x80000000) is treated as unsigned 0x80000000.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF yields Lo=0x80000000, Hi=0. No exception is raised.
- Operands and Op are captured at E0; later changes on the input ports have no effect.
- Hi/Lo change only on the DONE transition or on reset. Outside those events they hold their values indefinitely for repeated MFHI/MFLO reads.

Test Plan:
1. MULT A=7, B=0xFFFFFFFD (-3) -> Done exactly 32 edges after Start; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high for 33 cycles.
2. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
3. DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU A=100, B=7 -> Lo=14, Hi=2.
4. DIVU A=0x12345678, B=0 -> Done in the cycle after the Start edge, Div_Zero=1, Hi=0x12345678, Lo=0xFFFFFFFF. Next accepted Start clears Div_Zero.
5. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0x00000000, Div_Zero=0.
6. Start MULT 3*5; pulse Start with a different Op/operands at edge 10; then drop Reset_n at edge 20.
   - Second Start ignored (no restart); Hi/Lo stay at their pre-op values through edge 19.
   - Reset forces Busy=0, Done=0, Hi=Lo=0 immediately without waiting for a clock edge.
   - A fresh Start after reset yields Lo=15.
